// File: rtl/sha2_digest_streamer.sv
// Serialises sha2_top digest results into a byte stream.
// Framing is an optional ID/length header, then the digest MSB first.
module sha2_digest_streamer #(
  parameter bit HDR_EN     = 1'b1,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  ovalid,
  input  logic [31:0]           oid,
  input  logic [60:0]           olen,
  input  logic [511:0]          osha,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [7:0]            m_tdata,
  output logic                  m_tlast,
  output logic [31:0]           m_tid,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef struct packed {
    logic         mode;
    logic [31:0]  id;
    logic [63:0]  len;
    logic [511:0] sha;
  } slot_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ID,
    S_LEN,
    S_DIG
  } state_t;

  localparam state_t FIRST = HDR_EN ? S_ID : S_DIG;

  state_t     state;
  state_t     nstate;
  state_t     ls;
  logic [6:0] cnt;
  logic [6:0] ncnt;
  logic [6:0] lc;
  slot_t      act;
  slot_t      pnd;
  slot_t      nslot;
  slot_t      lslot;
  slot_t      in_slot;
  logic       act_vld;
  logic       pnd_vld;
  logic       promote;
  logic       hs;
  logic [7:0] ob_d;
  logic       ob_l;
  logic [31:0] ob_t;

  function automatic logic [6:0] seg_last(state_t s, logic md);
    unique case (s)
      S_ID:    seg_last = 7'd3;
      S_LEN:   seg_last = 7'd7;
      S_DIG:   seg_last = md ? 7'd63 : 7'd31;
      default: seg_last = 7'd0;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(
    state_t s, logic [6:0] c, slot_t sl
  );
    logic [1:0] bi;
    logic [2:0] bl;
    logic [5:0] bd;
    bi = 2'(7'd3 - c);
    bl = 3'(7'd7 - c);
    bd = 6'((sl.mode ? 7'd63 : 7'd31) - c);
    unique case (s)
      S_ID:    byte_of = sl.id[{bi, 3'b000} +: 8];
      S_LEN:   byte_of = sl.len[{bl, 3'b000} +: 8];
      S_DIG:   byte_of = sl.sha[{bd, 3'b000} +: 8];
      default: byte_of = 8'h00;
    endcase
  endfunction

  assign hs      = m_tvalid & m_tready;
  assign busy    = act_vld | pnd_vld;
  assign in_slot = {mode, oid, {3'b000, olen}, osha};

  // Where the byte counter goes after a handshake on the current byte.
  always_comb begin
    nstate  = state;
    ncnt    = cnt + 7'd1;
    nslot   = act;
    promote = 1'b0;
    if (cnt == seg_last(state, act.mode)) begin
      ncnt = '0;
      unique case (state)
        S_ID:  nstate = S_LEN;
        S_LEN: nstate = S_DIG;
        S_DIG: begin
          if (pnd_vld) begin
            promote = 1'b1;
            nstate  = FIRST;
            nslot   = pnd;
          end else begin
            nstate = S_IDLE;
          end
        end
        default: nstate = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ls    = hs ? nstate : state;
    lc    = hs ? ncnt : cnt;
    lslot = hs ? nslot : act;
    ob_d  = byte_of(ls, lc, lslot);
    ob_l  = (ls == S_DIG) && (lc == seg_last(ls, lslot.mode));
    ob_t  = ((ls == FIRST) && (lc == 7'd0)) ? lslot.id : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      act      <= '0;
      pnd      <= '0;
      act_vld  <= 1'b0;
      pnd_vld  <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
      drop_cnt <= '0;
    end else begin
      if (hs) begin
        state <= nstate;
        cnt   <= ncnt;
      end else if (state == S_IDLE && act_vld) begin
        state <= FIRST;
        cnt   <= '0;
      end

      if ((hs && nstate != S_IDLE) ||
          (!m_tvalid && state != S_IDLE)) begin
        m_tvalid <= 1'b1;
        m_tdata  <= ob_d;
        m_tlast  <= ob_l;
        m_tid    <= ob_t;
      end else if (hs) begin
        m_tvalid <= 1'b0;
        m_tdata  <= '0;
        m_tlast  <= 1'b0;
        m_tid    <= '0;
      end

      if (hs && nstate == S_IDLE) act_vld <= 1'b0;

      if (hs && promote) begin
        act     <= pnd;
        pnd_vld <= 1'b0;
      end else if (!act_vld && pnd_vld) begin
        act     <= pnd;
        act_vld <= 1'b1;
        pnd_vld <= 1'b0;
      end

      // Occupancy checks use the slot flags from before this edge.
      if (ovalid) begin
        if (!act_vld && !pnd_vld) begin
          act     <= in_slot;
          act_vld <= 1'b1;
        end else if (!pnd_vld || !act_vld) begin
          pnd     <= in_slot;
          pnd_vld <= 1'b1;
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha2_digest_streamer.sv
// Directed bench for sha2_digest_streamer with header and
// header-less instances sharing one stimulus.
module tb_sha2_digest_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic         ovalid;
  logic [31:0]  oid;
  logic [60:0]  olen;
  logic [511:0] osha;
  logic         m_tready;

  logic         v1, l1, b1;
  logic [7:0]   d1;
  logic [31:0]  t1;
  logic [7:0]   dc1;
  logic         v0, l0, b0;
  logic [7:0]   d0;
  logic [31:0]  t0;
  logic [7:0]   dc0;

  logic         sel;
  logic         cv, cl;
  logic [7:0]   cd;
  logic [31:0]  ct;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  localparam logic [511:0] S256X = {
    256'hdeadbeefcafef00d0badc0de5555aaaa,
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad
  };
  localparam logic [511:0] S512 =
    512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha2_digest_streamer #(.HDR_EN(1'b1), .DROP_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .ovalid(ovalid),
    .oid(oid), .olen(olen), .osha(osha),
    .m_tvalid(v1), .m_tready(m_tready), .m_tdata(d1),
    .m_tlast(l1), .m_tid(t1), .busy(b1), .drop_cnt(dc1)
  );

  sha2_digest_streamer #(.HDR_EN(1'b0), .DROP_CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .ovalid(ovalid),
    .oid(oid), .olen(olen), .osha(osha),
    .m_tvalid(v0), .m_tready(m_tready), .m_tdata(d0),
    .m_tlast(l0), .m_tid(t0), .busy(b0), .drop_cnt(dc0)
  );

  assign cv = sel ? v0 : v1;
  assign cd = sel ? d0 : d1;
  assign cl = sel ? l0 : l1;
  assign ct = sel ? t0 : t1;

  logic [7:0]  rd [256];
  logic        rl [256];
  logic [31:0] rt [256];
  int          rc [256];
  int          ncol;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(
    int i, bit md, bit hdr, logic [31:0] id,
    logic [63:0] len, logic [511:0] sha
  );
    logic [511:0] t;
    logic [63:0]  tl;
    logic [31:0]  ti;
    int k, nb;
    k = i;
    if (hdr) begin
      if (i < 4) begin
        ti = id >> (8 * (3 - i));
        return ti[7:0];
      end
      if (i < 12) begin
        tl = len >> (8 * (11 - i));
        return tl[7:0];
      end
      k = i - 12;
    end
    nb = md ? 64 : 32;
    t = sha >> (8 * (nb - 1 - k));
    return t[7:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ovalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input bit md, input logic [31:0] id,
                      input logic [60:0] len, input logic [511:0] sha);
    @(negedge clk);
    mode = md;
    oid = id;
    olen = len;
    osha = sha;
    ovalid = 1'b1;
  endtask

  task automatic collect(input int n, input bit bp);
    int k;
    logic pv, pr, pl;
    logic [7:0] pd;
    k = 0;
    pv = 1'b0;
    pr = 1'b0;
    pl = 1'b0;
    pd = '0;
    ncol = 0;
    while (ncol < n && k < 3000) begin
      @(negedge clk);
      ovalid = 1'b0;
      mode = k[0];
      m_tready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (pv && !pr) begin
        chk("stall.v", 64'(cv), 64'd1);
        chk("stall.d", 64'(cd), 64'(pd));
        chk("stall.l", 64'(cl), 64'(pl));
      end
      if (cv && m_tready) begin
        rd[ncol] = cd;
        rl[ncol] = cl;
        rt[ncol] = ct;
        rc[ncol] = cyc;
        ncol++;
      end
      pv = cv;
      pr = m_tready;
      pd = cd;
      pl = cl;
      k++;
    end
    if (ncol < n) chk("timeout", 64'(ncol), 64'(n));
  endtask

  task automatic check_frame(input string nm, input int base,
                             input int n, input bit md, input bit hdr,
                             input logic [31:0] id, input logic [63:0] len,
                             input logic [511:0] sha);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.d%0d", nm, i), 64'(rd[base + i]),
          64'(exp_byte(i, md, hdr, id, len, sha)));
      chk($sformatf("%s.l%0d", nm, i), 64'(rl[base + i]),
          64'(i == n - 1));
      chk($sformatf("%s.t%0d", nm, i), 64'(rt[base + i]),
          64'((i == 0) ? id : 32'd0));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mode = 1'b0;
    ovalid = 1'b0;
    oid = '0;
    olen = '0;
    osha = '0;
    m_tready = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.valid", 64'(v1), 64'd0);
    chk("rst.data", 64'(d1), 64'd0);
    chk("rst.last", 64'(l1), 64'd0);
    chk("rst.tid", 64'(t1), 64'd0);
    chk("rst.busy", 64'(b1), 64'd0);
    chk("rst.drop", 64'(dc1), 64'd0);
    chk("rst.valid0", 64'(v0), 64'd0);
    rst = 1'b0;

    // SHA-256 "abc" with header
    m_tready = 1'b1;
    send(1'b0, 32'h2561, 61'd3, S256X);
    collect(44, 1'b0);
    check_frame("s256", 0, 44, 1'b0, 1'b1, 32'h2561, 64'd3, S256X);
    chk("s256.b2", 64'(rd[2]), 64'h25);
    chk("s256.b3", 64'(rd[3]), 64'h61);
    chk("s256.b11", 64'(rd[11]), 64'h03);
    chk("s256.b12", 64'(rd[12]), 64'hba);
    chk("s256.b43", 64'(rd[43]), 64'had);
    chk("s256.tid0", 64'(rt[0]), 64'h2561);
    @(negedge clk);
    chk("s256.end", 64'(v1), 64'd0);
    chk("s256.busy", 64'(b1), 64'd0);

    // SHA-512 "abc"
    do_reset();
    send(1'b1, 32'h5121, 61'd3, S512);
    collect(76, 1'b0);
    check_frame("s512", 0, 76, 1'b1, 1'b1, 32'h5121, 64'd3, S512);
    chk("s512.b12", 64'(rd[12]), 64'hdd);
    chk("s512.b75", 64'(rd[75]), 64'h9f);
    chk("s512.l75", 64'(rl[75]), 64'd1);

    // back-pressure 1,0,0,1
    do_reset();
    send(1'b0, 32'h2561, 61'd3, S256X);
    collect(44, 1'b1);
    check_frame("bp", 0, 44, 1'b0, 1'b1, 32'h2561, 64'd3, S256X);

    // queue: third result dropped, two frames back to back
    do_reset();
    m_tready = 1'b0;
    send(1'b0, 32'd1, 61'd10, 512'h1111);
    send(1'b0, 32'd2, 61'd20, 512'h2222);
    send(1'b0, 32'd3, 61'd30, 512'h3333);
    @(negedge clk);
    ovalid = 1'b0;
    chk("q.drop", 64'(dc1), 64'd1);
    chk("q.busy", 64'(b1), 64'd1);
    collect(88, 1'b0);
    check_frame("q1", 0, 44, 1'b0, 1'b1, 32'd1, 64'd10, 512'h1111);
    check_frame("q2", 44, 44, 1'b0, 1'b1, 32'd2, 64'd20, 512'h2222);
    chk("q.gap", 64'(rc[44] - rc[43]), 64'd1);
    @(negedge clk);
    chk("q.busy_end", 64'(b1), 64'd0);
    chk("q.valid_end", 64'(v1), 64'd0);
    chk("q.drop_end", 64'(dc1), 64'd1);

    // header-less instance
    do_reset();
    sel = 1'b1;
    m_tready = 1'b1;
    send(1'b0, 32'habcd01, 61'd3, S256X);
    collect(32, 1'b0);
    check_frame("nohdr", 0, 32, 1'b0, 1'b0, 32'habcd01, 64'd3, S256X);
    chk("nohdr.b0", 64'(rd[0]), 64'hba);
    chk("nohdr.tid", 64'(rt[0]), 64'habcd01);
    @(negedge clk);
    chk("nohdr.end", 64'(v0), 64'd0);
    sel = 1'b0;

    // reset after byte 20 of a SHA-512 frame
    do_reset();
    send(1'b1, 32'h77, 61'd3, S512);
    collect(21, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr.valid", 64'(v1), 64'd0);
    chk("mr.last", 64'(l1), 64'd0);
    chk("mr.drop", 64'(dc1), 64'd0);
    chk("mr.busy", 64'(b1), 64'd0);
    send(1'b1, 32'h78, 61'd3, S512);
    collect(76, 1'b0);
    check_frame("mr", 0, 76, 1'b1, 1'b1, 32'h78, 64'd3, S512);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
